// File: rtl/qdr_phase_select.sv
// Four-phase ADC sample retiming, one-shot eye calibration and phase selection.
// Every register is in the clk_0 domain; the calibration FSM picks the phase farthest from the data edge.
module qdr_phase_select #(
    parameter int width    = 8,
    parameter int WIN_LOG2 = 10
) (
    input  logic             clk_0,
    input  logic             reset,
    input  logic [width-1:0] data0,
    input  logic [width-1:0] data90,
    input  logic [width-1:0] data180,
    input  logic [width-1:0] data270,
    input  logic             cal_start,
    output logic             cal_busy,
    output logic             cal_done,
    output logic             cal_fail,
    output logic [1:0]       phase_sel,
    output logic [width-1:0] data_out,
    output logic             data_valid
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        ACCUM  = 3'd2,
        DECIDE = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t state;

    logic [width-1:0] d0_r, d90_r, d180_r, d270_r;
    logic [width-1:0] d0_rr, d90_rr, d180_rr, d270_rr;
    logic [3:0]       m;

    logic [WIN_LOG2:0]   e_cnt [4];
    logic [WIN_LOG2-1:0] win_cnt;

    logic [1:0]        best_k;
    logic [WIN_LOG2:0] best_v;

    always_ff @(posedge clk_0 or posedge reset) begin
        if (reset) begin
            d0_r    <= '0;
            d90_r   <= '0;
            d180_r  <= '0;
            d270_r  <= '0;
            d0_rr   <= '0;
            d90_rr  <= '0;
            d180_rr <= '0;
            d270_rr <= '0;
        end else begin
            d0_r    <= data0;
            d90_r   <= data90;
            d180_r  <= data180;
            d270_r  <= data270;
            d0_rr   <= d0_r;
            d90_rr  <= d90_r;
            d180_rr <= d180_r;
            d270_rr <= d270_r;
        end
    end

    // Pair 3 wraps to the next cycle's 0-degree sample, which is d0_r relative to d270_rr.
    always_comb begin
        m[0] = (d0_rr   != d90_rr);
        m[1] = (d90_rr  != d180_rr);
        m[2] = (d180_rr != d270_rr);
        m[3] = (d270_rr != d0_r);
    end

    always_ff @(posedge clk_0 or posedge reset) begin
        if (reset) begin
            data_out <= '0;
        end else begin
            case (phase_sel)
                2'd0:    data_out <= d0_rr;
                2'd1:    data_out <= d90_rr;
                2'd2:    data_out <= d180_rr;
                default: data_out <= d270_rr;
            endcase
        end
    end

    // Strict '>' keeps the lowest index on ties.
    always_comb begin
        best_k = 2'd0;
        best_v = e_cnt[0];
        for (int k = 1; k < 4; k++) begin
            if (e_cnt[k] > best_v) begin
                best_v = e_cnt[k];
                best_k = 2'(k);
            end
        end
    end

    always_ff @(posedge clk_0 or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cal_busy   <= 1'b0;
            cal_done   <= 1'b0;
            cal_fail   <= 1'b0;
            phase_sel  <= 2'd0;
            data_valid <= 1'b0;
            win_cnt    <= '0;
            for (int k = 0; k < 4; k++) e_cnt[k] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cal_start) begin
                        cal_done <= 1'b0;
                        cal_fail <= 1'b0;
                        cal_busy <= 1'b1;
                        state    <= CLEAR;
                    end
                end
                CLEAR: begin
                    win_cnt <= '0;
                    for (int k = 0; k < 4; k++) e_cnt[k] <= '0;
                    state <= ACCUM;
                end
                ACCUM: begin
                    for (int k = 0; k < 4; k++)
                        e_cnt[k] <= e_cnt[k] + {{WIN_LOG2{1'b0}}, m[k]};
                    win_cnt <= win_cnt + 1'b1;
                    if (win_cnt == '1) state <= DECIDE;
                end
                DECIDE: begin
                    // The sampling point opposite the noisiest pair sits half a period from the edge.
                    if (best_v == '0) begin
                        cal_fail <= 1'b1;
                    end else begin
                        phase_sel  <= best_k + 2'd2;
                        data_valid <= 1'b1;
                    end
                    state <= DONE;
                end
                DONE: begin
                    cal_done <= 1'b1;
                    cal_busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
